scramble_ctrl: RTL and testbench

SCRAMBLE_CTRL -- requirements
Module: scramble_ctrl

---
 rtl/scramble_pkg.sv | 25 ++
 rtl/scramble_core.sv | 38 +++
 rtl/scramble_ctrl.sv | 154 +++++++++++++++
 tb/tb_scramble_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scramble_pkg.sv
// -----------------------------------------------------------------------------
// scramble_pkg
// Shared constants and types for the scramble controller.
//   SCR_W        data / key word width
//   SCR_NW       round-count width
//   scr_state_t  controller FSM state encoding
//   scr_rotl1    rotate a word left by one (MSB wraps to bit 0); used by the
//                optional key rotation (SCRAMBLE_CTRL_KEYROT_EN)
// -----------------------------------------------------------------------------
package scramble_pkg;

   localparam int SCR_W  = 5;
   localparam int SCR_NW = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } scr_state_t;

   function automatic logic [SCR_W-1:0] scr_rotl1(input logic [SCR_W-1:0] v);
      return {v[SCR_W-2:0], v[SCR_W-1]};
   endfunction

endpackage

// File: rtl/scramble_core.sv
// -----------------------------------------------------------------------------
// scramble_core
// Purely combinational round function A = F(ip, k). All bit indices wrap
// modulo SCR_W:
//   A[i] = (~ip[i+2] & ~ip[i-1] & ~ip[i-2] & ip[i+1]) | (~ip[i] & k[i])
//        | (ip[i] & ip[i+2])
// Ports:
//   ip  in   current data word
//   k   in   round mask word
//   A   out  next data word
// -----------------------------------------------------------------------------
module scramble_core
   import scramble_pkg::*;
(
   input  logic [SCR_W-1:0] ip,
   input  logic [SCR_W-1:0] k,
   output logic [SCR_W-1:0] A
);

   // Wrapped neighbour indices are resolved at elaboration time so every
   // bit select is a constant.
   for (genvar gi = 0; gi < SCR_W; gi++) begin : g_bit
      localparam int P1 = (gi + 1) % SCR_W;
      localparam int P2 = (gi + 2) % SCR_W;
      localparam int M1 = (gi + SCR_W - 1) % SCR_W;
      localparam int M2 = (gi + SCR_W - 2) % SCR_W;

      logic w_t_shift;
      logic w_t_mask;
      logic w_t_keep;

      assign w_t_shift = ~ip[P2] & ~ip[M1] & ~ip[M2] & ip[P1];
      assign w_t_mask  = ~ip[gi] & k[gi];
      assign w_t_keep  =  ip[gi] & ip[P2];
      assign A[gi]     = w_t_shift | w_t_mask | w_t_keep;
   end

endmodule

// File: rtl/scramble_ctrl.sv
// -----------------------------------------------------------------------------
// scramble_ctrl
// Job controller around scramble_core. A job captures seed/key/rounds on the
// start-accept edge, applies N rounds (one per clock), then presents the
// result with out_valid until the consumer acknowledges.
//
// Optional feature (compile-time macro): SCRAMBLE_CTRL_KEYROT_EN
//   defined   : key register rotates left by 1 after each round is applied
//   undefined : key register is constant for the whole job
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   job request, sampled only in IDLE
//   seed[4:0]  in   initial data word
//   key[4:0]   in   per-round mask word
//   rounds[3:0]in   round count N (0..15)
//   busy       out  high in RUN and DONE
//   out_valid  out  high only in DONE
//   out_ack    in   consumer acknowledge, honoured only in DONE
//   result[4:0]out  data register (stable while out_valid)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; registers hold the last job's values
// RUN   | one round per clock until the count reaches its last round
// DONE  | result presented, waiting for out_ack
// -----------------------------------------------------------------------------
module scramble_ctrl
   import scramble_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SCR_W-1:0]  seed,
   input  logic [SCR_W-1:0]  key,
   input  logic [SCR_NW-1:0] rounds,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ack,
   output logic [SCR_W-1:0]  result
);

   scr_state_t        r_state;
   scr_state_t        w_next_state;

   logic [SCR_W-1:0]  r_data;
   logic [SCR_W-1:0]  r_key;
   logic [SCR_NW-1:0] r_cnt;

   logic [SCR_W-1:0]  w_round;
   logic              w_accept;
   logic              w_last_round;

   scramble_core u_core (
      .ip (r_data),
      .k  (r_key),
      .A  (w_round)
   );

   assign w_accept     = (r_state == ST_IDLE) && start;
   assign w_last_round = (r_cnt == SCR_NW'(1));

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               // A zero-round job skips RUN and presents the seed directly.
               w_next_state = (rounds != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            // A RUN entered with a zero count cannot happen; leave anyway
            // rather than wrapping through 16 rounds.
            if (w_last_round || (r_cnt == '0)) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ack) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Output logic (Moore)
   // ---------------------------------------------------------------
   always_comb begin
      busy      = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         ST_RUN: begin
            busy = 1'b1;
         end
         ST_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
         end
         default: begin
            busy      = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   assign result = r_data;

   // ---------------------------------------------------------------
   // Datapath registers: only written on accept and in RUN, so the
   // result is frozen through DONE and held afterwards in IDLE.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
         r_key  <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_accept) begin
            r_data <= seed;
            r_key  <= key;
            r_cnt  <= rounds;
         end else if (r_state == ST_RUN) begin
            r_data <= w_round;
            r_cnt  <= r_cnt - SCR_NW'(1);
`ifdef SCRAMBLE_CTRL_KEYROT_EN
            r_key  <= scr_rotl1(r_key);
`else
            r_key  <= r_key;
`endif
         end
      end
   end

endmodule

// File: tb/tb_scramble_ctrl.sv
module tb_scramble_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [4:0] seed;
   logic [4:0] key;
   logic [3:0] rounds;
   logic       busy;
   logic       out_valid;
   logic       out_ack;
   logic [4:0] result;

   scramble_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .seed      (seed),
      .key       (key),
      .rounds    (rounds),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .result    (result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event did not occur (t=%0t)", name, $time);
   endtask

   // Reference model: round rule evaluated bit by bit with wrapped indices.
   function automatic logic [4:0] ref_round(input logic [4:0] d, input logic [4:0] k);
      logic [4:0] a;
      for (int i = 0; i < 5; i++) begin
         a[i] = (!d[(i+2)%5] && !d[(i+4)%5] && !d[(i+3)%5] && d[(i+1)%5])
             || (!d[i] && k[i])
             || (d[i] && d[(i+2)%5]);
      end
      return a;
   endfunction

   function automatic logic [4:0] ref_scramble(input logic [4:0] s, input logic [4:0] k, input int n);
      logic [4:0] d;
      int         kk;
      d  = s;
      kk = k;
      for (int r = 0; r < n; r++) begin
         d = ref_round(d, kk[4:0]);
`ifdef SCRAMBLE_CTRL_KEYROT_EN
         kk = ((kk * 2) + (kk / 16)) % 32;
`endif
      end
      return d;
   endfunction

   typedef struct {
      logic [4:0] res;
      int         vcyc;
      string      tag;
   } exp_t;

   exp_t q[$];

   // Monitor: pops an expectation on every rising out_valid; checks hold stability.
   initial begin
      logic       prev_v;
      logic [4:0] held;
      exp_t       e;
      prev_v = 1'b0;
      held   = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
         end else begin
            if (out_valid && !prev_v) begin
               if (q.size() == 0) begin
                  fail_now("unexpected_out_valid");
               end else begin
                  e = q.pop_front();
                  chk({e.tag, " result"}, result, e.res);
                  chk({e.tag, " latency_cycle"}, cyc, e.vcyc);
               end
               held = result;
            end else if (out_valid && prev_v) begin
               chk("result_stable_in_done", result, held);
            end
            prev_v = out_valid;
         end
      end
   end

   task automatic recover();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      q.delete();
      start   = 1'b0;
      out_ack = 1'b0;
   endtask

   task automatic run_job(input string tag, input logic [4:0] s, input logic [4:0] k,
                          input logic [3:0] n, input int ack_dly, input bit disturb,
                          input bit start_with_ack, input int rst_after, input bit skip_wait);
      int   guard;
      int   a;
      exp_t e;
      if (!skip_wait) begin
         guard = 0;
         @(negedge clk);
         while (busy && guard < 40) begin
            @(negedge clk);
            guard++;
         end
         if (busy) begin
            fail_now({tag, " idle_wait"});
            recover();
            return;
         end
      end
      seed   = s;
      key    = k;
      rounds = n;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = cyc;
      e.res  = ref_scramble(s, k, int'(n));
      e.vcyc = a + int'(n);
      e.tag  = tag;
      q.push_back(e);
      chk({tag, " busy_after_accept"}, busy, 1);

      guard = 0;
      @(negedge clk);
      while (!out_valid && guard < 20) begin
         chk({tag, " busy_in_run"}, busy, 1);
         if (rst_after >= 0 && guard == rst_after) begin
            #1;
            rst = 1'b1;
            #1;
            chk({tag, " rst_busy"}, busy, 0);
            chk({tag, " rst_out_valid"}, out_valid, 0);
            chk({tag, " rst_result"}, result, 0);
            q.delete();
            start   = 1'b0;
            out_ack = 1'b0;
            #1;
            rst = 1'b0;
            return;
         end
         if (disturb) begin
            seed    = 5'($urandom);
            key     = 5'($urandom);
            rounds  = 4'($urandom);
            start   = 1'($urandom);
            out_ack = 1'($urandom);
         end
         @(negedge clk);
         guard++;
      end
      start   = 1'b0;
      out_ack = 1'b0;
      if (!out_valid) begin
         fail_now({tag, " out_valid_timeout"});
         recover();
         return;
      end

      for (int i = 0; i < ack_dly; i++) begin
         chk({tag, " valid_hold"}, {busy, out_valid}, 2'b11);
         @(negedge clk);
      end
      out_ack = 1'b1;
      if (start_with_ack) start = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, " ack_to_idle"}, {busy, out_valid}, 2'b00);
      out_ack = 1'b0;
      start   = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      out_ack = 1'b0;
      seed    = '0;
      key     = '0;
      rounds  = '0;
      #23;
      chk("reset_busy", busy, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_result", result, 0);
      #4;
      rst = 1'b0;

      // First start lands on the first rising edge after reset release.
      run_job("single_bit_rotate", 5'b00010, 5'b00000, 4'd3, 0, 1'b0, 1'b0, -1, 1'b1);
      chk("single_bit_rotate held_result", result, 5'b01000);

      run_job("all_ones_hold10", 5'b00000, 5'b11111, 4'd5, 10, 1'b0, 1'b0, -1, 1'b0);
      chk("all_ones held_result", result, 5'b11111);

      run_job("zero_rounds", 5'b10110, 5'($urandom), 4'd0, 2, 1'b0, 1'b0, -1, 1'b0);
      chk("zero_rounds held_result", result, 5'b10110);

      run_job("rst_mid_run", 5'($urandom), 5'($urandom), 4'd15, 0, 1'b0, 1'b0, 5, 1'b0);
      run_job("after_rst", 5'($urandom), 5'($urandom), 4'd7, 1, 1'b0, 1'b0, -1, 1'b1);

      run_job("disturbed", 5'b01101, 5'b10011, 4'd9, 1, 1'b1, 1'b1, -1, 1'b0);
      run_job("start_with_ack_next", 5'b11001, 5'b00110, 4'd2, 0, 1'b0, 1'b1, -1, 1'b0);

      for (int j = 0; j < 60; j++) begin
         run_job("random", 5'($urandom), 5'($urandom), 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), -1, 1'b0);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      chk("final_idle", {busy, out_valid}, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
